mem_port_arbiter: RTL and testbench

- Shares the single memory port of the multi-cycle core between the core's fetch/load/store requests and an auxiliary requester (debug/DMA loader).
- Sequences one outstanding transaction at a time to a variable-latency memory using a req/gnt/rvalid handshake.
- Generates the per-requester `done` pulse that the core control FSM consumes to advance its cycle counter.
- Core has priority. A starvation counter guarantees the aux requester eventual service.

---
 rtl/mem_port_arbiter_pkg.sv | 36 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the core memory port arbiter
//
// Purpose: enums shared by the memory-side blocks of the multi-cycle core.
//   mem_op_t    : kind of memory access the core control FSM issues
//   mem_src_t   : which unit originated an access
//   arb_state_t : memory port arbiter sequencing states
//   mem_owner_t : requester currently holding the memory port
// Ports: none (package).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_OP_FETCH = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_t;

  typedef enum logic {
    SRC_CORE = 1'b0,
    SRC_AUX  = 1'b1
  } mem_src_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_AUX  = 1'b1
  } mem_owner_t;

  // Wide enough for the full legal MAX_STARVE range (1..15).
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for core and aux requesters
//
// Purpose: shares one req/gnt/rvalid memory port between the core and an
// auxiliary requester, one outstanding transaction at a time. Core has
// priority; the aux requester is forced through after MAX_STARVE consecutive
// core grants made while it was waiting.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata/c_be core request (held until c_done)
//   c_done, c_rdata                core completion pulse and read data
//   a_*                            same set for the aux requester
//   m_req/m_we/m_addr/m_wdata/m_be memory request side
//   m_gnt, m_rvalid, m_rdata       memory accept, response, read data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  input  logic [DATA_W/8-1:0] c_be,
  output logic                c_done,
  output logic [DATA_W-1:0]   c_rdata,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_be,
  output logic                a_done,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  arb_state_t          state, next_state;
  mem_owner_t          owner;
  logic [STARVE_W-1:0] starve_cnt;
  logic                grant;
  logic                grant_aux;

  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W/8-1:0] lat_be;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_aux  = 1'b0;
    m_req      = 1'b0;
    c_done     = 1'b0;
    a_done     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (c_req || a_req) begin
          grant      = 1'b1;
          // Core wins ties unless aux has been passed over MAX_STARVE times.
          grant_aux  = a_req && (!c_req || (starve_cnt == STARVE_MAX));
          next_state = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        m_req = 1'b1;
        if (m_gnt) begin
          next_state = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        // Responses are only honoured here; a stray m_rvalid elsewhere
        // (including one left over from before a reset) is dropped.
        if (m_rvalid) begin
          c_done     = (owner == OWN_CORE);
          a_done     = (owner == OWN_AUX);
          next_state = ARB_IDLE;
        end
      end
      default: begin
        next_state = ARB_IDLE;
      end
    endcase
  end

  // Request latch and owner: captured only on a grant, so requester changes
  // during ISSUE/WAIT never reach the memory bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_CORE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (grant) begin
      owner     <= grant_aux ? OWN_AUX : OWN_CORE;
      lat_we    <= grant_aux ? a_we    : c_we;
      lat_addr  <= grant_aux ? a_addr  : c_addr;
      lat_wdata <= grant_aux ? a_wdata : c_wdata;
      lat_be    <= grant_aux ? a_be    : c_be;
    end
  end

  // Counts core grants that bypassed a waiting aux request; saturates so the
  // forced aux grant fires exactly once the limit is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (!a_req || grant_aux) begin
        starve_cnt <= '0;
      end else if (grant && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign m_we    = lat_we;
  assign m_addr  = lat_addr;
  assign m_wdata = lat_wdata;
  assign m_be    = lat_be;

  assign c_rdata = m_rdata;
  assign a_rdata = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, a_req, a_we;
  logic [31:0] c_addr, c_wdata, a_addr, a_wdata;
  logic [3:0]  c_be, a_be;
  logic        c_done, a_done;
  logic [31:0] c_rdata, a_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_done(c_done), .c_rdata(c_rdata),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_done(a_done), .a_rdata(a_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full minimum-latency transaction starting from IDLE with requests set.
  // exp_aux selects which requester must win; exp_addr is that requester's address.
  task automatic run_txn(input string tag, input logic exp_aux, input logic [31:0] exp_addr,
                         input logic [31:0] rdata);
    tick();
    check({tag, "_mreq"}, {31'd0, m_req}, 32'd1);
    check({tag, "_maddr"}, m_addr, exp_addr);
    m_gnt = 1'b1;
    tick();
    m_gnt    = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = rdata;
    #1;
    check({tag, "_cdone"}, {31'd0, c_done}, {31'd0, ~exp_aux});
    check({tag, "_adone"}, {31'd0, a_done}, {31'd0, exp_aux});
    tick();
    m_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    tick(); tick();
    check("rst_mreq",  {31'd0, m_req},  32'd0);
    check("rst_cdone", {31'd0, c_done}, 32'd0);
    check("rst_adone", {31'd0, a_done}, 32'd0);
    check("rst_mwe",   {31'd0, m_we},   32'd0);
    check("rst_maddr", m_addr,          32'd0);
    check("rst_mwdata", m_wdata,        32'd0);
    check("rst_mbe",   {28'd0, m_be},   32'd0);
    rst = 1'b0;
    tick();

    // Single core read, immediate grant.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h100; c_be = 4'hF;
    tick();
    check("rd_mreq",  {31'd0, m_req}, 32'd1);
    check("rd_maddr", m_addr,         32'h100);
    check("rd_mwe",   {31'd0, m_we},  32'd0);
    check("rd_cdone_early", {31'd0, c_done}, 32'd0);
    m_gnt = 1'b1;
    tick();
    check("rd_mreq_wait", {31'd0, m_req}, 32'd0);
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
    #1;
    check("rd_cdone", {31'd0, c_done}, 32'd1);
    check("rd_crdata", c_rdata,        32'hDEADBEEF);
    check("rd_adone", {31'd0, a_done}, 32'd0);
    c_req = 1'b0;
    tick();
    m_rvalid = 1'b0;
    #1;
    check("rd_cdone_after", {31'd0, c_done}, 32'd0);

    // Aux write with grant stalled 3 cycles; aux fields change mid-ISSUE.
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h40; a_wdata = 32'h12345678; a_be = 4'hF;
    tick();
    a_addr = 32'h99; a_wdata = 32'h0; a_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("st_mreq",   {31'd0, m_req}, 32'd1);
      check("st_maddr",  m_addr,         32'h40);
      check("st_mwdata", m_wdata,        32'h12345678);
      check("st_mwe",    {31'd0, m_we},  32'd1);
      check("st_mbe",    {28'd0, m_be},  32'hF);
      if (i == 1) begin
        // Stray response during ISSUE must not complete anything.
        m_rvalid = 1'b1;
        #1;
        check("st_stray_adone", {31'd0, a_done}, 32'd0);
        m_rvalid = 1'b0;
      end
      if (i == 3) m_gnt = 1'b1;
      tick();
    end
    m_gnt = 1'b0; m_rvalid = 1'b1;
    #1;
    check("st_adone", {31'd0, a_done}, 32'd1);
    check("st_cdone", {31'd0, c_done}, 32'd0);
    a_req = 1'b0;
    tick();
    m_rvalid = 1'b0;

    // Starvation: both held, expect C C C C A C C C C A.
    c_req = 1'b1; c_addr = 32'h200; c_we = 1'b0;
    a_req = 1'b1; a_addr = 32'h300; a_we = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (t == 4 || t == 9) run_txn("sv_aux", 1'b1, 32'h300, 32'hA0 + t);
      else                  run_txn("sv_core", 1'b0, 32'h200, 32'hC0 + t);
    end
    c_req = 1'b0; a_req = 1'b0;
    tick();

    // Simultaneous requests: core first, aux next once core drops.
    c_req = 1'b1; c_addr = 32'h500;
    a_req = 1'b1; a_addr = 32'h600;
    tick();
    check("sim_first_maddr", m_addr, 32'h500);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; m_rvalid = 1'b1;
    #1;
    check("sim_first_cdone", {31'd0, c_done}, 32'd1);
    c_req = 1'b0;
    tick();
    m_rvalid = 1'b0;
    run_txn("sim_second", 1'b1, 32'h600, 32'h55);
    a_req = 1'b0;
    tick();

    // Reset while in WAIT; late response must be dropped.
    c_req = 1'b1; c_addr = 32'h700;
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    rst = 1'b1; c_req = 1'b0;
    tick();
    rst = 1'b0;
    check("rw_mreq",  {31'd0, m_req}, 32'd0);
    check("rw_maddr", m_addr,         32'd0);
    tick(); tick();
    m_rvalid = 1'b1;
    #1;
    check("rw_late_cdone", {31'd0, c_done}, 32'd0);
    check("rw_late_adone", {31'd0, a_done}, 32'd0);
    check("rw_late_mreq",  {31'd0, m_req},  32'd0);
    tick();
    m_rvalid = 1'b0;
    c_req = 1'b1; c_addr = 32'h704;
    run_txn("rw_next", 1'b0, 32'h704, 32'h77);
    c_req = 1'b0;
    tick();

    // Stray response in IDLE with no request pending.
    m_rvalid = 1'b1;
    #1;
    check("idle_stray_cdone", {31'd0, c_done}, 32'd0);
    check("idle_stray_adone", {31'd0, a_done}, 32'd0);
    tick();
    m_rvalid = 1'b0;
    check("idle_stray_mreq", {31'd0, m_req}, 32'd0);
    a_req = 1'b1; a_addr = 32'h800;
    run_txn("idle_next", 1'b1, 32'h800, 32'h88);
    a_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
